// File: rtl/pixel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pixel_ctrl_pkg : state encoding and phase-length constants for pixel_row_ctrl
// Rev 1.0 - initial release
// ============================================================================
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int ADC_STEPS     = 256;
  localparam int DEF_NUM_ROWS  = 2;
  localparam int DEF_ERASE_CYC = 5;
  localparam int DEF_READ_CYC  = 5;
  // Wide enough for the ADC ramp and any realistic erase/read length.
  localparam int TIMER_W       = 16;

endpackage
`default_nettype wire

// File: rtl/pixel_row_ctrl_if.sv
`default_nettype none
// ============================================================================
// pixel_row_ctrl_if : frame request / status handshake of pixel_row_ctrl
// Rev 1.0 - initial release
// ============================================================================
interface pixel_row_ctrl_if;
  logic       start;
  logic [7:0] expose_cyc;
  logic       busy;
  logic       done;

  modport master (output start, output expose_cyc, input busy, input done);
  modport slave  (input start, input expose_cyc, output busy, output done);
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// phase_timer : loadable down-counter; o_zero marks the last cycle of a phase
// Rev 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_load_val,
  input  wire logic         i_tick,
  output logic              o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_row_ctrl.sv
`default_nettype none
// ============================================================================
// pixel_row_ctrl : erase/expose/convert/read sequencer for a pixel row array.
// PIXEL_ROW_CTRL_CONTINUOUS_EN: start in DONE re-enters ERASE without IDLE.
// Rev 1.0 - initial release
// ============================================================================
module pixel_row_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int NUM_ROWS  = DEF_NUM_ROWS,
  parameter int ERASE_CYC = DEF_ERASE_CYC,
  parameter int READ_CYC  = DEF_READ_CYC,
  localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pixel_row_ctrl_if.slave   bus,
  output logic              o_erase,
  output logic              o_expose,
  output logic              o_convert,
  output logic              o_read,
  output logic [7:0]        o_adc_count,
  output logic [ROW_W-1:0]  o_row_sel,
  output logic              o_row_valid
);

  localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_exp;
  logic [7:0]           r_adc;
  logic [ROW_W-1:0]     r_row;
  logic                 w_zero;
  logic                 w_load;
  logic                 w_accept;
  logic [TIMER_W-1:0]   w_load_val;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (r_state != ST_IDLE),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Each phase loads its length minus one, so the timer hits zero on its last cycle.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_accept   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept   = 1'b1;
          w_next     = ST_ERASE;
          w_load     = 1'b1;
          w_load_val = TIMER_W'(ERASE_CYC - 1);
        end
      end
      ST_ERASE: begin
        if (w_zero) begin
          w_next     = ST_EXPOSE;
          w_load     = 1'b1;
          w_load_val = (r_exp == 8'd0) ? '0 : TIMER_W'(r_exp - 8'd1);
        end
      end
      ST_EXPOSE: begin
        if (w_zero) begin
          w_next     = ST_CONVERT;
          w_load     = 1'b1;
          w_load_val = TIMER_W'(ADC_STEPS - 1);
        end
      end
      ST_CONVERT: begin
        if (w_zero) begin
          w_next     = ST_READ;
          w_load     = 1'b1;
          w_load_val = TIMER_W'(READ_CYC - 1);
        end
      end
      ST_READ: begin
        if (w_zero) begin
          if (r_row == c_LAST_ROW) begin
            w_next = ST_DONE;
          end else begin
            w_load     = 1'b1;
            w_load_val = TIMER_W'(READ_CYC - 1);
          end
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
`ifdef PIXEL_ROW_CTRL_CONTINUOUS_EN
        if (bus.start) begin
          w_accept   = 1'b1;
          w_next     = ST_ERASE;
          w_load     = 1'b1;
          w_load_val = TIMER_W'(ERASE_CYC - 1);
        end
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp <= '0;
      r_adc <= '0;
      r_row <= '0;
    end else begin
      if (w_accept) r_exp <= bus.expose_cyc;
      if ((r_state == ST_CONVERT) && !w_zero) r_adc <= r_adc + 8'd1;
      else                                    r_adc <= '0;
      if ((r_state == ST_READ) && w_zero)
        r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + ROW_W'(1);
    end
  end

  always_comb begin
    o_erase     = (r_state == ST_ERASE);
    o_expose    = (r_state == ST_EXPOSE);
    o_convert   = (r_state == ST_CONVERT);
    o_read      = (r_state == ST_READ);
    o_row_valid = (r_state == ST_READ) && w_zero;
  end

  assign o_adc_count = r_adc;
  assign o_row_sel   = r_row;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pixel_row_ctrl : directed bench; DUT A default rows, DUT B 4 rows x 3 cycles
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_row_ctrl;

  localparam int RA = 5;
  localparam int RB = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_row_ctrl_if ifa ();
  pixel_row_ctrl_if ifb ();

  logic       er_a, ex_a, cv_a, rd_a, rv_a;
  logic [7:0] adc_a;
  logic [0:0] rs_a;
  logic       er_b, ex_b, cv_b, rd_b, rv_b;
  logic [7:0] adc_b;
  logic [1:0] rs_b;

  pixel_row_ctrl #(.NUM_ROWS(2), .ERASE_CYC(5), .READ_CYC(RA)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .o_erase(er_a), .o_expose(ex_a), .o_convert(cv_a), .o_read(rd_a),
    .o_adc_count(adc_a), .o_row_sel(rs_a), .o_row_valid(rv_a)
  );

  pixel_row_ctrl #(.NUM_ROWS(4), .ERASE_CYC(5), .READ_CYC(RB)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .o_erase(er_b), .o_expose(ex_b), .o_convert(cv_b), .o_read(rd_b),
    .o_adc_count(adc_b), .o_row_sel(rs_b), .o_row_valid(rv_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  int n_er, n_ex, n_cv, n_rd_a, n_rd_b, row_err_a, row_err_b;
  int adc_err, adc_last, oh_err, busy_err, done_a, done_b, n_done_a, first_er;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] e);
    ifa.start = s;  ifb.start = s;
    ifa.expose_cyc = e;  ifb.expose_cyc = e;
  endtask

  // Starts one frame and observes it cycle by cycle; cycle 1 is the first after acceptance.
  task automatic run_frame(input logic [7:0] ecyc, input int pulse_at);
    int cyc;
    int adc_exp;
    n_er = 0; n_ex = 0; n_cv = 0; n_rd_a = 0; n_rd_b = 0; row_err_a = 0; row_err_b = 0;
    adc_err = 0; adc_last = -1; oh_err = 0; busy_err = 0; done_a = -1; done_b = -1;
    n_done_a = 0; first_er = 0; adc_exp = 0;
    drive(1'b1, ecyc);
    tick();
    cyc = 1;
    drive(1'b0, 8'hA5);
    while (cyc < 400) begin
      if (cyc == 1) first_er = int'(er_a);
      if (er_a) n_er++;
      if (ex_a) n_ex++;
      if (cv_a) begin
        if (int'(adc_a) != adc_exp) adc_err++;
        adc_last = int'(adc_a);
        adc_exp++;
        n_cv++;
      end else if (adc_a != 8'd0) begin
        adc_err++;
      end
      if (rd_a) begin
        if ((int'(rs_a) != n_rd_a / RA) || (rv_a != ((n_rd_a % RA) == RA - 1))) row_err_a++;
        n_rd_a++;
      end else if (rv_a) begin
        row_err_a++;
      end
      if (rd_b) begin
        if ((int'(rs_b) != n_rd_b / RB) || (rv_b != ((n_rd_b % RB) == RB - 1))) row_err_b++;
        n_rd_b++;
      end else if (rv_b) begin
        row_err_b++;
      end
      if (done_a < 0) begin
        if ($countones({er_a, ex_a, cv_a, rd_a, ifa.done}) != 1) oh_err++;
        if (!ifa.busy) busy_err++;
      end
      if (ifa.done) begin
        n_done_a++;
        if (done_a < 0) done_a = cyc;
      end
      if (ifb.done && done_b < 0) done_b = cyc;
      if (done_a >= 0 && done_b >= 0) break;
      ifa.start = (cyc == pulse_at);
      ifb.start = (cyc == pulse_at);
      tick();
      cyc++;
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int gap;
    int idle_seen;
    drive(1'b0, 8'd0);
    #3;
    check_val("rst_out_a", {ifa.busy, ifa.done, er_a, ex_a, cv_a, rd_a, rv_a, adc_a, rs_a}, 0);
    check_val("rst_out_b", {ifb.busy, ifb.done, er_b, ex_b, cv_b, rd_b, rv_b, adc_b, rs_b}, 0);
    tick();
    tick();
    reset = 1'b0;

    // Nominal frame, expose 10; expose_cyc is changed right after acceptance.
    run_frame(8'd10, -1);
    check_val("a_first_erase", first_er, 1);
    check_val("a_erase_len", n_er, 5);
    check_val("a_expose_len", n_ex, 10);
    check_val("a_convert_len", n_cv, 256);
    check_val("a_adc_seq_err", adc_err, 0);
    check_val("a_adc_last", adc_last, 255);
    check_val("a_read_len", n_rd_a, 10);
    check_val("a_row_err", row_err_a, 0);
    check_val("a_done_cyc", done_a, 282);
    check_val("a_done_pulses", n_done_a, 1);
    check_val("a_onehot_err", oh_err, 0);
    check_val("a_busy_err", busy_err, 0);
    check_val("a_busy_after", ifa.busy, 0);
    check_val("b_read_len", n_rd_b, 12);
    check_val("b_row_err", row_err_b, 0);
    check_val("b_done_cyc", done_b, 284);

    // expose_cyc = 0 and a start pulse during CONVERT.
    tick();
    tick();
    run_frame(8'd0, 100);
    check_val("z_expose_len", n_ex, 1);
    check_val("z_convert_len", n_cv, 256);
    check_val("z_adc_seq_err", adc_err, 0);
    check_val("z_done_a", done_a, 273);
    check_val("z_done_b", done_b, 275);
    tick(); tick(); tick();
    check_val("z_no_restart", ifa.busy, 0);

    // Asynchronous reset in the middle of EXPOSE.
    drive(1'b1, 8'd20);
    tick();
    drive(1'b0, 8'd20);
    repeat (7) tick();
    check_val("r_in_expose", ex_a, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("r_async_a", {ifa.busy, ifa.done, er_a, ex_a, cv_a, rd_a, rv_a, adc_a, rs_a}, 0);
    check_val("r_async_b", {ifb.busy, ifb.done, er_b, ex_b, cv_b, rd_b, rv_b, adc_b, rs_b}, 0);
    tick();
    check_val("r_held_busy", ifa.busy, 0);
    reset = 1'b0;
    run_frame(8'd3, -1);
    check_val("r_first_erase", first_er, 1);
    check_val("r_erase_len", n_er, 5);
    check_val("r_expose_len", n_ex, 3);
    check_val("r_done_cyc", done_a, 275);
    check_val("r_adc_seq_err", adc_err, 0);

    // start held high across the frame boundary.
    tick();
    drive(1'b1, 8'd2);
    cyc = 0;
    while (!ifa.done && cyc < 400) begin
      tick();
      cyc++;
    end
    check_val("c_done_cyc", cyc, 274);
    gap = 0;
    idle_seen = 0;
    do begin
      tick();
      gap++;
      if (!ifa.busy) idle_seen = 1;
    end while (!er_a && gap < 10);
`ifdef PIXEL_ROW_CTRL_CONTINUOUS_EN
    check_val("c_erase_gap", gap, 1);
    check_val("c_idle_seen", idle_seen, 0);
`else
    check_val("c_erase_gap", gap, 2);
    check_val("c_idle_seen", idle_seen, 1);
`endif
    drive(1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
